// File: rtl/cp0_exc_ctrl_pkg.sv
// rtl/cp0_exc_ctrl_pkg.sv - shared CP0 register indices, field positions and exception codes
//
// Purpose : constants and helpers shared by cp0_exc_ctrl and cp0_req_arb.
// Ports   : none (package).
package cp0_exc_ctrl_pkg;

   // CP0 register indices (mfc0/mtc0 rd field)
   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   // Field bit positions
   localparam int SR_IE      = 0;
   localparam int SR_EXL     = 1;
   localparam int IM_LO      = 10;
   localparam int IM_HI      = 15;
   localparam int CAUSE_BD   = 31;
   localparam int EXCCODE_LO = 2;
   localparam int EXCCODE_HI = 6;

   // Exception codes
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // Word-align a PC by dropping the byte offset.
   function automatic logic [31:0] align_word(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// rtl/cp0_req_arb.sv - combinational interrupt/exception request arbitration
//
// Purpose : decides whether the M-stage instruction is interrupted or faults,
//           and which ExcCode gets recorded. Holds no state.
// Ports   : hw_int[5:0]   interrupt lines
//           im[5:0]       SR.IM mask
//           ie, exl       SR.IE / SR.EXL
//           exc_code_in   synchronous exception code, 0 = none
//           req           take exception/interrupt
//           exc_code_sel  ExcCode to record (interrupt wins, records 0)
module cp0_req_arb
   import cp0_exc_ctrl_pkg::*;
(
   input  logic [5:0] hw_int,
   input  logic [5:0] im,
   input  logic       ie,
   input  logic       exl,
   input  logic [4:0] exc_code_in,
   output logic       req,
   output logic [4:0] exc_code_sel
);

   logic int_req;
   logic exc_req;

   // EXL masks everything, so nested requests never fire inside a handler.
   assign int_req      = (|(hw_int & im)) & ie & ~exl;
   assign exc_req      = (exc_code_in != 5'd0) & ~exl;
   assign req          = int_req | exc_req;
   assign exc_code_sel = int_req ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception/interrupt controller at the M stage
//
// Purpose : holds SR, Cause, EPC, PRId; raises Req to flush and redirect the
//           pipeline; serves mfc0 (A1/Dout), mtc0 (A2/Din/We) and eret (EXLClr).
// Ports   : clk, reset (async, active-high)
//           A1 read index, Dout read data (combinational, no write bypass)
//           A2/Din/We mtc0 write
//           PCIn, BDIn, ExcCodeIn  M-stage instruction info
//           HWInt[5:0] level-sensitive interrupts, EXLClr eret
//           Req take exception (combinational), EPCOut current EPC
module cp0_exc_ctrl
   import cp0_exc_ctrl_pkg::*;
#(
   parameter logic [31:0] PRID_VAL = 32'h0000_0700,
   parameter logic [31:0] EPC_RST  = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] Din,
   input  logic        We,
   input  logic [31:0] PCIn,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic        Req,
   output logic [31:0] EPCOut,
   output logic [31:0] Dout
);

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;

   logic        arb_req;
   logic [4:0]  exc_code_sel;
   logic [31:0] epc_take;
   logic        wr_sr;
   logic        wr_epc;
   logic        unused_pc_lsbs;

   cp0_req_arb u_arb (
      .hw_int       (HWInt),
      .im           (im),
      .ie           (ie),
      .exl          (exl),
      .exc_code_in  (ExcCodeIn),
      .req          (arb_req),
      .exc_code_sel (exc_code_sel)
   );

   // ExcCodeIn can be nonzero while reset is held; Req must still stay low.
   assign Req = arb_req & ~reset;

   // A delay-slot instruction restarts at its branch, one word earlier.
   assign epc_take = BDIn ? (align_word(PCIn) - 32'd4) : align_word(PCIn);

   assign wr_sr  = We && (A2 == CP0_SR);
   assign wr_epc = We && (A2 == CP0_EPC);

   assign unused_pc_lsbs = ^PCIn[1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         epc      <= EPC_RST;
      end else begin
         ip <= HWInt;
         if (Req) begin
            exl      <= 1'b1;
            bd       <= BDIn;
            exc_code <= exc_code_sel;
            epc      <= epc_take;
         end else if (EXLClr) begin
            // eret wins over the EXL bit of a concurrent SR write.
            exl <= 1'b0;
            if (wr_sr) begin
               im <= Din[IM_HI:IM_LO];
               ie <= Din[SR_IE];
            end
         end else begin
            if (wr_sr) begin
               im  <= Din[IM_HI:IM_LO];
               exl <= Din[SR_EXL];
               ie  <= Din[SR_IE];
            end
            if (wr_epc) begin
               epc <= align_word(Din);
            end
         end
      end
   end

   assign EPCOut = epc;

   always_comb begin
      Dout = 32'd0;
      case (A1)
         CP0_SR:    Dout = {16'd0, im, 8'd0, exl, ie};
         CP0_CAUSE: Dout = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
         CP0_EPC:   Dout = epc;
         CP0_PRID:  Dout = PRID_VAL;
         default:   Dout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - self-checking bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] Din;
   logic        We;
   logic [31:0] PCIn;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic        Req;
   logic [31:0] EPCOut;
   logic [31:0] Dout;

   int n_vec  = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   cp0_exc_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .A1        (A1),
      .A2        (A2),
      .Din       (Din),
      .We        (We),
      .PCIn      (PCIn),
      .BDIn      (BDIn),
      .ExcCodeIn (ExcCodeIn),
      .HWInt     (HWInt),
      .EXLClr    (EXLClr),
      .Req       (Req),
      .EPCOut    (EPCOut),
      .Dout      (Dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural model: whole-register images with writable-bit masks.
   logic [31:0] sr_m;
   logic [31:0] cause_m;
   logic [31:0] epc_m;

   function automatic logic m_int();
      return (|(HWInt & sr_m[15:10])) && sr_m[0] && !sr_m[1];
   endfunction

   function automatic logic m_req();
      return !reset && (m_int() || ((ExcCodeIn != 5'd0) && !sr_m[1]));
   endfunction

   function automatic logic [31:0] sr_next();
      if (m_req())                      return sr_m | 32'h2;
      if (EXLClr && We && A2 == 5'd12)  return Din & 32'h0000_FC01;
      if (EXLClr)                       return sr_m & ~32'h2;
      if (We && A2 == 5'd12)            return Din & 32'h0000_FC03;
      return sr_m;
   endfunction

   function automatic logic [31:0] cause_next();
      logic [31:0] c;
      c = cause_m;
      if (m_req()) begin
         c[31]  = BDIn;
         c[6:2] = m_int() ? 5'd0 : ExcCodeIn;
      end
      c[15:10] = HWInt;
      return c;
   endfunction

   function automatic logic [31:0] epc_next();
      if (m_req())                        return (PCIn & ~32'd3) - (BDIn ? 32'd4 : 32'd0);
      if (!EXLClr && We && A2 == 5'd14)   return Din & ~32'd3;
      return epc_m;
   endfunction

   function automatic logic [31:0] m_dout(input logic [4:0] a);
      case (a)
         5'd12:   return sr_m;
         5'd13:   return cause_m;
         5'd14:   return epc_m;
         5'd15:   return 32'h0000_0700;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_m    <= 32'd0;
         cause_m <= 32'd0;
         epc_m   <= 32'h0000_3000;
      end else begin
         sr_m    <= sr_next();
         cause_m <= cause_next();
         epc_m   <= epc_next();
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model compare, every cycle once checking is enabled.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_req",  {31'd0, Req}, {31'd0, m_req()});
         chk("model_epc",  EPCOut, epc_m);
         chk("model_dout", Dout, m_dout(A1));
      end
   end

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      We = 1'b0; EXLClr = 1'b0; ExcCodeIn = 5'd0; BDIn = 1'b0; HWInt = 6'd0;
   endtask

   task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
      A1 = a;
      #1;
      chk(name, Dout, exp);
   endtask

   task automatic eret();
      idle();
      EXLClr = 1'b1;
      next();
      EXLClr = 1'b0;
   endtask

   initial begin
      reset = 1'b0; A1 = 5'd0; A2 = 5'd0; Din = 32'd0; PCIn = 32'h0000_3000;
      idle();
      #3 reset = 1'b1;
      ExcCodeIn = 5'd10;
      #1 chk("req_in_reset", {31'd0, Req}, 32'd0);
      next();
      ExcCodeIn = 5'd0;
      #5 reset = 1'b0;
      next();
      chk_en = 1'b1;

      // 1. reset state
      rd("rst_sr", 5'd12, 32'd0);
      rd("rst_cause", 5'd13, 32'd0);
      rd("rst_epc", 5'd14, 32'h0000_3000);
      rd("rst_prid", 5'd15, 32'h0000_0700);
      rd("rst_other", 5'd3, 32'd0);
      chk("rst_req", {31'd0, Req}, 32'd0);

      // 2. enable timer IRQ, then take it
      We = 1'b1; A2 = 5'd12; Din = 32'h0000_0401;
      next();
      We = 1'b0; HWInt = 6'b000001; PCIn = 32'h0000_3023;
      #1 chk("irq_req", {31'd0, Req}, 32'd1);
      next();
      rd("irq_sr", 5'd12, 32'h0000_0403);
      rd("irq_cause", 5'd13, 32'h0000_0400);
      chk("irq_epc", EPCOut, 32'h0000_3020);
      chk("irq_req_masked", {31'd0, Req}, 32'd0);

      // 5. level IRQ re-fires after eret
      EXLClr = 1'b1;
      #1 chk("eret_cycle_req", {31'd0, Req}, 32'd0);
      next();
      EXLClr = 1'b0;
      #1 chk("refire_req", {31'd0, Req}, 32'd1);
      next();
      HWInt = 6'd0;

      // 3. RI in a delay slot
      eret();
      ExcCodeIn = 5'd10; BDIn = 1'b1; PCIn = 32'h0000_3010;
      #1 chk("ri_req", {31'd0, Req}, 32'd1);
      next();
      idle();
      chk("ri_epc", EPCOut, 32'h0000_300C);
      rd("ri_cause", 5'd13, 32'h8000_0028);

      // nested request masked while EXL = 1
      ExcCodeIn = 5'd5;
      #1 chk("nested_mask", {31'd0, Req}, 32'd0);
      next();
      idle();

      // 4. interrupt beats Ov; concurrent mtc0 EPC dropped
      eret();
      HWInt = 6'b000001; ExcCodeIn = 5'd12; We = 1'b1; A2 = 5'd14;
      Din = 32'h0000_5554; PCIn = 32'h0000_4000;
      next();
      idle();
      chk("prio_epc", EPCOut, 32'h0000_4000);
      rd("prio_cause", 5'd13, 32'h0000_0400);

      // 6. mtc0 EPC with same-cycle mfc0: no bypass
      eret();
      We = 1'b1; A2 = 5'd14; Din = 32'h0000_3007;
      rd("nobypass_old", 5'd14, 32'h0000_4000);
      next();
      We = 1'b0;
      rd("nobypass_new", 5'd14, 32'h0000_3004);

      // read-only Cause and PRId
      We = 1'b1; A2 = 5'd13; Din = 32'hFFFF_FFFF;
      next();
      A2 = 5'd15;
      next();
      We = 1'b0;
      rd("cause_ro", 5'd13, 32'h0000_0000);
      rd("prid_ro", 5'd15, 32'h0000_0700);

      // EPC wrap: delay slot at PC 2
      ExcCodeIn = 5'd4; BDIn = 1'b1; PCIn = 32'h0000_0002;
      next();
      idle();
      chk("epc_wrap", EPCOut, 32'hFFFF_FFFC);
      rd("wrap_cause", 5'd13, 32'h8000_0010);

      // eret with concurrent SR write keeps EXL 0
      We = 1'b1; A2 = 5'd12; Din = 32'h0000_0403; EXLClr = 1'b1;
      next();
      idle();
      rd("eret_sr_write", 5'd12, 32'h0000_0401);

      // reset mid-handler
      ExcCodeIn = 5'd12;
      next();
      ExcCodeIn = 5'd5;
      #1 chk("in_handler_mask", {31'd0, Req}, 32'd0);
      reset = 1'b1;
      #1 chk("midreset_req", {31'd0, Req}, 32'd0);
      rd("midreset_sr", 5'd12, 32'd0);
      rd("midreset_epc", 5'd14, 32'h0000_3000);
      next();
      reset = 1'b0;
      ExcCodeIn = 5'd0;
      next();
      next();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
